// File: rtl/range_stat.sv
// Mini-batch statistics for range batch normalization: accumulates sum and
// max/min over MINI_BATCH samples and emits mean and (max - min) * C(n).
module range_stat #(
    parameter int DATA_WIDTH  = 16,
    parameter int MINI_BATCH  = 64,
    parameter int ADDR_WIDTH  = $clog2(MINI_BATCH),
    parameter int SCALE       = 89,
    parameter int SCALE_WIDTH = 8,
    parameter int SCALE_SHIFT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  clear,
    output logic                  busy,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] stan_dev_out,
    output logic [DATA_WIDTH-1:0] avg_out
);

    localparam int SUM_WIDTH   = DATA_WIDTH + ADDR_WIDTH;
    localparam int RANGE_WIDTH = DATA_WIDTH + 1;
    localparam int PROD_WIDTH  = RANGE_WIDTH + SCALE_WIDTH;

    localparam logic [SCALE_WIDTH-1:0] SCALE_V = SCALE_WIDTH'(SCALE);
    localparam logic [DATA_WIDTH-1:0]  SD_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    logic        [ADDR_WIDTH-1:0]  cnt_r;
    logic signed [SUM_WIDTH-1:0]   sum_r;
    logic signed [DATA_WIDTH-1:0]  max_r;
    logic signed [DATA_WIDTH-1:0]  min_r;
    logic                          busy_r;
    logic                          valid_out_r;
    logic        [DATA_WIDTH-1:0]  avg_out_r;
    logic        [DATA_WIDTH-1:0]  stan_dev_out_r;

    logic        [0:0]             state_s;
    logic                          accept_s;
    logic                          last_s;
    logic signed [SUM_WIDTH-1:0]   data_ext_s;
    logic signed [SUM_WIDTH-1:0]   sum_nxt_s;
    logic signed [DATA_WIDTH-1:0]  max_nxt_s;
    logic signed [DATA_WIDTH-1:0]  min_nxt_s;
    logic        [ADDR_WIDTH-1:0]  cnt_nxt_s;
    logic        [RANGE_WIDTH-1:0] range_s;
    logic        [PROD_WIDTH-1:0]  prod_s;
    logic        [PROD_WIDTH-1:0]  sd_full_s;
    logic        [DATA_WIDTH-1:0]  avg_s;

    // Clamp the scaled range to the largest positive DATA_WIDTH value.
    function automatic logic [DATA_WIDTH-1:0] sat_sd(input logic [PROD_WIDTH-1:0] v);
        if (v > {{(PROD_WIDTH-DATA_WIDTH){1'b0}}, SD_MAX}) begin
            sat_sd = SD_MAX;
        end else begin
            sat_sd = v[DATA_WIDTH-1:0];
        end
    endfunction

    // Next accumulator state and the batch results derived from it.
    always_comb begin
        state_s    = (cnt_r == {ADDR_WIDTH{1'b0}}) ? IDLE : ACCUM;
        accept_s   = valid_in & ~clear;
        last_s     = accept_s & (&cnt_r);
        data_ext_s = {{ADDR_WIDTH{data_in[DATA_WIDTH-1]}}, data_in};
        sum_nxt_s  = data_ext_s;
        max_nxt_s  = data_in;
        min_nxt_s  = data_in;
        case (state_s)
            IDLE: begin
                sum_nxt_s = data_ext_s;
                max_nxt_s = data_in;
                min_nxt_s = data_in;
            end
            ACCUM: begin
                sum_nxt_s = sum_r + data_ext_s;
                max_nxt_s = ($signed(data_in) > max_r) ? data_in : max_r;
                min_nxt_s = ($signed(data_in) < min_r) ? data_in : min_r;
            end
            default: begin
                sum_nxt_s = data_ext_s;
                max_nxt_s = data_in;
                min_nxt_s = data_in;
            end
        endcase

        if (clear) begin
            cnt_nxt_s = {ADDR_WIDTH{1'b0}};
        end else if (accept_s) begin
            // A full batch wraps the power-of-two counter back to zero.
            cnt_nxt_s = cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end

        range_s   = {max_nxt_s[DATA_WIDTH-1], max_nxt_s} - {min_nxt_s[DATA_WIDTH-1], min_nxt_s};
        prod_s    = PROD_WIDTH'(range_s) * PROD_WIDTH'(SCALE_V);
        sd_full_s = prod_s >> SCALE_SHIFT;
        avg_s     = sum_nxt_s[ADDR_WIDTH +: DATA_WIDTH];
    end

    // Sample counter, busy flag and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {ADDR_WIDTH{1'b0}};
            busy_r <= 1'b0;
            sum_r  <= {SUM_WIDTH{1'b0}};
            max_r  <= {DATA_WIDTH{1'b0}};
            min_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            cnt_r  <= cnt_nxt_s;
            busy_r <= (cnt_nxt_s != {ADDR_WIDTH{1'b0}});
            if (accept_s) begin
                sum_r <= sum_nxt_s;
                max_r <= max_nxt_s;
                min_r <= min_nxt_s;
            end
        end
    end

    // Result registers: capture on the last sample, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out_r    <= 1'b0;
            avg_out_r      <= {DATA_WIDTH{1'b0}};
            stan_dev_out_r <= {DATA_WIDTH{1'b0}};
        end else begin
            valid_out_r <= last_s;
            if (last_s) begin
                avg_out_r      <= avg_s;
                stan_dev_out_r <= sat_sd(sd_full_s);
            end
        end
    end

    assign busy         = busy_r;
    assign valid_out    = valid_out_r;
    assign avg_out      = avg_out_r;
    assign stan_dev_out = stan_dev_out_r;

endmodule
